stage_mem: RTL
==============

# stage_mem

Memory stage of the cyyrv64 in-order pipeline. Sits directly downstream of the execute stage and consumes its resolved effective address, store data, funct3 and ALU result. Issues at most one data-memory transaction per instruction over a valid/ready request and response channel, aligns and sign-extends load data, and registers the result toward writeback. Stalls upstream with `mem_ready` until the transaction completes, and drains a flushed in-flight access without side effects.

## Interface
Parameters:
- `XLEN`, 64: datapath width (only 64 is supported).

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset; asynchronous and active-high.
- `mem_flush`  in  1  kill the instruction currently in this stage.
- `mem_ready`  out  1  current instruction completes this cycle; upstream holds all `in_*` stable while this is 0.
- `in_valid`  in  1  an instruction is present.
- `in_mem_en`  in  1  instruction is a load or store.
- `in_mem_write`  in  1  1 = store, 0 = load.
- `in_funct3`  in  3  access size and signedness.
- `in_addr`  in  64  effective address.
- `in_wdata`  in  64  store data (rs2).
- `in_alu_out`  in  64  result for non-memory instructions.
- `dmem_req_valid`  out  1  request valid.
- `dmem_req_ready`  in  1  request accepted.
- `dmem_req_write`  out  1  store request.
- `dmem_req_addr`  out  64  `{in_addr[63:3], 3'b0}`.
- `dmem_req_wdata`  out  64  store data replicated to lane.
- `dmem_req_wstrb`  out  8  byte enables.
- `dmem_rsp_valid`  in  1  response or store acknowledge; one per accepted request.
- `dmem_rsp_rdata`  in  64  aligned doubleword read data.
- `out_valid`  out  1  registered result valid to writeback.
- `out_result`  out  64  registered load data or ALU result.
- `out_misaligned`  out  1  registered misaligned-access flag.

## Operation
- FSM states: IDLE, REQ, RESP, DRAIN.
- **IDLE:**
  - Non-memory or `in_valid`=0: `mem_ready`=`in_valid`.
  - Memory op with a misaligned address: `mem_ready`=1, no request is issued, and `out_misaligned`=1 is registered.
    - LH/LHU misaligned: `addr[0]`≠0.
    - LW/LWU/SW misaligned: `addr[1:0]`≠0.
    - LD/SD misaligned: `addr[2:0]`≠0.
  - Aligned memory op: `dmem_req_valid`=1 combinationally from the inputs. Handshake → RESP, otherwise → REQ.
- **REQ:** `dmem_req_valid` is held with stable fields until `dmem_req_ready`, then → RESP.
- **RESP:** on `dmem_rsp_valid`, `mem_ready`=1 and → IDLE. Load data is captured the same edge.
- **DRAIN:** `mem_ready`=0. On `dmem_rsp_valid`, discard the response and → IDLE.
- **Load alignment:**
  - `sh = addr[2:0]*8`; extract `rdata >> sh`.
  - funct3 000 LB, 001 LH, 010 LW, 011 LD: sign-extend.
  - funct3 100 LBU, 101 LHU, 110 LWU: zero-extend.
- **Store:**
  - Data is `in_wdata` of the access size replicated across 64 bits.
  - `wstrb` = size mask (0x01/0x03/0x0F/0xFF) `<< addr[2:0]`.
- **Flush:**
  - In IDLE, or in REQ with `dmem_req_ready`=0: abandon the access, stay or go to IDLE, and issue no request.
  - Same cycle as a request handshake, or in RESP without `dmem_rsp_valid`: → DRAIN.
  - In RESP with `dmem_rsp_valid`: → IDLE and discard the data.
  - Flush always forces `out_valid`=0 at the next edge.

## Timing
- Reset values:
  - State: IDLE.
  - `out_valid`=0, `out_result`=0, `out_misaligned`=0.
  - `dmem_req_valid`=0 in IDLE with no input.
- Non-memory instructions: result visible on `out_*` one cycle after `in_valid` (0-cycle stall).
- Memory instructions:
  - `out_valid` rises the cycle after `dmem_rsp_valid`.
  - Best case, with ready in cycle 0 and response in cycle 1: result visible in cycle 2 (1 stall cycle).
- `out_valid` is a single-cycle pulse per completed instruction. Writeback always accepts.
- A response in the same cycle as the request handshake is not allowed; the memory responds at least one cycle later.
- Reset mid-transaction drops to IDLE immediately. The memory side is reset by the same `rst`.

## Structure
- In the shared def_common package:
  - funct3 size constants: `LB`, `LH`, `LW`, `LD`, `LBU`, `LHU`, `LWU`.
  - `mem_state_t` enum.
- Sub-module `mem_align`: combinational. Computes load extract/extend, store replicate, wstrb and the misaligned check.

## Test plan
- ADD with `alu_out`=0x1234, `in_valid`=1 → `mem_ready`=1 same cycle; next cycle `out_valid`=1, `out_result`=0x1234, no dmem request.
- LB at addr 0x1003, rdata=0x0000_0000_8000_0000, ready immediate, response next cycle → `out_result`=0xFFFF_FFFF_FFFF_FF80, 1 stall cycle; repeat as LBU → 0x80.
- SH at addr 0x2006, wdata=0xABCD, `req_ready` low 3 cycles → request fields stable throughout; `wstrb`=0xC0, `wdata`=0xABCD_ABCD_ABCD_ABCD, addr 0x2000; completes on ack.
- LW at addr 0x3002 → no request; `out_misaligned`=1 next cycle, `mem_ready`=1 same cycle.
- LD accepted, then flush in RESP; response arrives 4 cycles later with 0xDEAD → `mem_ready` stays 0 until the response, data discarded, `out_valid` never set.
- Assert `rst` while in REQ → state IDLE and all outputs at reset values without waiting for a clock edge.

Source files
------------

// File: rtl/def_common_pkg.sv
// def_common: constants and types shared by the memory stage.
//   - funct3 encodings for load/store size and signedness (stores share the
//     low two bits with the loads of the same size).
//   - mem_state_t: state of the data-memory transaction sequencer.
//   - size_mask(): byte-enable pattern for an access size at offset 0.
package def_common;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LD  = 3'b011;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] LWU = 3'b110;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP,
        DRAIN
    } mem_state_t;

    // size is funct3[1:0]: 0 byte, 1 half, 2 word, 3 double.
    function automatic logic [7:0] size_mask(input logic [1:0] size);
        case (size)
            2'd0:    return 8'h01;
            2'd1:    return 8'h03;
            2'd2:    return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/stage_mem_align.sv
// mem_align: purely combinational lane logic for the memory stage.
//   funct3     in   access size and signedness
//   offset     in   byte offset within the doubleword (addr[2:0])
//   wdata      in   store data (rs2)
//   rdata      in   aligned doubleword read data
//   load_data  out  extracted and sign/zero-extended load value
//   store_data out  store data replicated across all lanes of its size
//   wstrb      out  byte enables for the store
//   misaligned out  access does not sit on its natural boundary
module mem_align
    import def_common::*;
(
    input  logic [2:0]  funct3,
    input  logic [2:0]  offset,
    input  logic [63:0] wdata,
    input  logic [63:0] rdata,
    output logic [63:0] load_data,
    output logic [63:0] store_data,
    output logic [7:0]  wstrb,
    output logic        misaligned
);

    logic [63:0] shifted;

    // Bring the addressed byte down to lane 0.
    assign shifted = rdata >> {offset, 3'b000};

    // NOTE: each always_comb assigns its outputs a default before the case so
    // no path leaves them unassigned, which would infer a latch.
    always_comb begin
        load_data = shifted;
        case (funct3)
            LB:      load_data = {{56{shifted[7]}},  shifted[7:0]};
            LH:      load_data = {{48{shifted[15]}}, shifted[15:0]};
            LW:      load_data = {{32{shifted[31]}}, shifted[31:0]};
            LD:      load_data = shifted;
            LBU:     load_data = {56'b0, shifted[7:0]};
            LHU:     load_data = {48'b0, shifted[15:0]};
            LWU:     load_data = {32'b0, shifted[31:0]};
            default: load_data = shifted;
        endcase
    end

    // Replicating the data lets the byte enables alone pick the lane.
    always_comb begin
        store_data = wdata;
        case (funct3[1:0])
            2'd0:    store_data = {8{wdata[7:0]}};
            2'd1:    store_data = {4{wdata[15:0]}};
            2'd2:    store_data = {2{wdata[31:0]}};
            default: store_data = wdata;
        endcase
    end

    assign wstrb = size_mask(funct3[1:0]) << offset;

    always_comb begin
        misaligned = 1'b0;
        case (funct3[1:0])
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = offset[0];
            2'd2:    misaligned = |offset[1:0];
            default: misaligned = |offset;
        endcase
    end

endmodule

// File: rtl/stage_mem.sv
// stage_mem: memory stage of the in-order pipeline.
// Issues at most one data-memory transaction per instruction, stalls upstream
// via mem_ready until it completes, and registers the result to writeback.
//   clk, rst              clock, asynchronous active-high reset
//   mem_flush             kill the instruction currently in this stage
//   mem_ready             instruction completes this cycle
//   in_*                  instruction from execute (held while mem_ready=0)
//   dmem_req_*            request channel (valid/ready)
//   dmem_rsp_*            response / store acknowledge channel
//   out_valid/result/misaligned  registered result to writeback
module stage_mem
    import def_common::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mem_flush,
    output logic            mem_ready,
    input  logic            in_valid,
    input  logic            in_mem_en,
    input  logic            in_mem_write,
    input  logic [2:0]      in_funct3,
    input  logic [XLEN-1:0] in_addr,
    input  logic [XLEN-1:0] in_wdata,
    input  logic [XLEN-1:0] in_alu_out,
    output logic            dmem_req_valid,
    input  logic            dmem_req_ready,
    output logic            dmem_req_write,
    output logic [XLEN-1:0] dmem_req_addr,
    output logic [XLEN-1:0] dmem_req_wdata,
    output logic [7:0]      dmem_req_wstrb,
    input  logic            dmem_rsp_valid,
    input  logic [XLEN-1:0] dmem_rsp_rdata,
    output logic            out_valid,
    output logic [XLEN-1:0] out_result,
    output logic            out_misaligned
);

    mem_state_t      state, state_next;
    logic [XLEN-1:0] load_data, store_data, next_result;
    logic [7:0]      wstrb;
    logic            misaligned, mem_op, ready_c, req_valid_c, complete;

    mem_align u_align (
        .funct3     (in_funct3),
        .offset     (in_addr[2:0]),
        .wdata      (in_wdata),
        .rdata      (dmem_rsp_rdata),
        .load_data  (load_data),
        .store_data (store_data),
        .wstrb      (wstrb),
        .misaligned (misaligned)
    );

    assign mem_op = in_valid && in_mem_en;

    // Request fields come straight from the held inputs, so they stay stable
    // for as long as the request is pending.
    assign dmem_req_write = in_mem_write;
    assign dmem_req_addr  = {in_addr[XLEN-1:3], 3'b000};
    assign dmem_req_wdata = store_data;
    assign dmem_req_wstrb = wstrb;

    // Held low during reset so the outputs read as idle immediately.
    assign dmem_req_valid = req_valid_c && !rst;
    assign mem_ready      = ready_c && !rst;

    always_comb begin
        state_next  = state;
        ready_c     = 1'b0;
        req_valid_c = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid && (!in_mem_en || misaligned)) begin
                    ready_c = 1'b1;
                end else if (mem_op) begin
                    if (mem_flush) begin
                        // Killed before anything was issued: just let it go.
                        ready_c = 1'b1;
                    end else begin
                        req_valid_c = 1'b1;
                        state_next  = dmem_req_ready ? RESP : REQ;
                    end
                end
            end
            REQ: begin
                req_valid_c = 1'b1;
                if (dmem_req_ready) begin
                    // Once accepted, the response must still be absorbed.
                    state_next = mem_flush ? DRAIN : RESP;
                end else if (mem_flush) begin
                    ready_c    = 1'b1;
                    state_next = IDLE;
                end
            end
            RESP: begin
                if (dmem_rsp_valid) begin
                    ready_c    = 1'b1;
                    state_next = IDLE;
                end else if (mem_flush) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (dmem_rsp_valid) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // A flushed instruction never reaches writeback.
    assign complete = ready_c && !mem_flush;

    always_comb begin
        next_result = load_data;
        if (!in_mem_en)                     next_result = in_alu_out;
        else if (misaligned || in_mem_write) next_result = '0;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            out_valid      <= 1'b0;
            out_result     <= '0;
            out_misaligned <= 1'b0;
        end else begin
            state     <= state_next;
            out_valid <= complete;
            if (complete) begin
                out_result     <= next_result;
                out_misaligned <= in_mem_en && misaligned;
            end
        end
    end

endmodule
